// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator: format encodings,
// default datapath width and the handshake state encoding.
package imm_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    FMT_I  = 3'b000,
    FMT_B  = 3'b001,
    FMT_J  = 3'b010,
    FMT_S  = 3'b011,
    FMT_U  = 3'b100,
    FMT_IU = 3'b101,
    FMT_Z  = 3'b110,
    FMT_SH = 3'b111
  } imm_fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction from a raw instruction word.
// Bits above each field are filled with the sign bit or zeros.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      fmt,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_fmt_e'(fmt))
      FMT_I: begin
        imm       = {XLEN{instr[31]}};
        imm[11:0] = instr[31:20];
      end
      FMT_B: begin
        imm       = {XLEN{instr[31]}};
        imm[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      FMT_J: begin
        imm       = {XLEN{instr[31]}};
        imm[20:0] = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      FMT_S: begin
        imm       = {XLEN{instr[31]}};
        imm[11:0] = {instr[31:25], instr[11:7]};
      end
      FMT_U: begin
        imm       = {XLEN{instr[31]}};
        imm[31:0] = {instr[31:12], 12'b0};
      end
      FMT_IU: imm[11:0] = instr[31:20];
      FMT_Z:  imm[4:0]  = instr[19:15];
      FMT_SH: begin
        // RV64 shift amounts carry one extra bit
        if (XLEN == 64) imm[5:0] = instr[25:20];
        else            imm[4:0] = instr[24:20];
      end
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a valid/ready output stage and a one-deep skid
// buffer, so the input side can stay ready for a cycle of back-pressure.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_EMPTY | nothing held, out_valid low
// ST_ONE   | output register holds a result
// ST_FULL  | output and skid registers both hold results, in_ready low
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_fmt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flush
);

  pipe_state_e      state_q, state_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             ready_q, ready_d;
  logic [XLEN-1:0]  dec_imm;
  logic             in_xfer;
  logic             out_xfer;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr (in_instr),
    .fmt   (in_fmt),
    .imm   (dec_imm)
  );

  // ready_q resets high; the rst gate keeps in_ready low while reset is held
  assign in_ready  = ready_q & ~rst;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_imm   = out_imm_q;
  assign out_tag   = out_tag_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    out_imm_d  = out_imm_q;
    out_tag_d  = out_tag_q;
    skid_imm_d = skid_imm_q;
    skid_tag_d = skid_tag_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          out_imm_d = dec_imm;
          out_tag_d = in_tag;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && !out_xfer) begin
          skid_imm_d = dec_imm;
          skid_tag_d = in_tag;
          state_d    = ST_FULL;
        end else if (in_xfer && out_xfer) begin
          out_imm_d = dec_imm;
          out_tag_d = in_tag;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          out_imm_d = skid_imm_q;
          out_tag_d = skid_tag_q;
          state_d   = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
    ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      out_imm_q  <= '0;
      out_tag_q  <= '0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_imm_q  <= out_imm_d;
      out_tag_q  <= out_tag_d;
      skid_imm_q <= skid_imm_d;
      skid_tag_q <= skid_tag_d;
      ready_q    <= ready_d;
    end
  end

endmodule
